// File: rtl/ps2_kbd_matrix.sv
// ps2_kbd_matrix
//   Receives a PS/2 scan-code set 2 keyboard stream and maintains the 64-bit
//   key matrix read by the Blink keyboard port. Scan codes are looked up in an
//   external ROM (1-cycle read latency) that returns {valid, index[5:0]}.
//
// Ports
//   mck       master clock (9.83MHz), rising edge
//   rin_n     asynchronous active-low reset
//   ps2_clk   PS/2 clock, asynchronous to mck
//   ps2_dat   PS/2 data, asynchronous to mck
//   map_addr  ROM address {ext, scancode}
//   map_data  ROM data {valid, index[5:0]}, valid 1 cycle after map_addr
//   kbmat     key matrix, bit 8*row+col is 1 while the key is held
//   kb_any    registered OR of kbmat
//   kb_event  1-cycle pulse when a kbmat bit is written
//   kb_err    1-cycle pulse on framing, parity or timeout error
module ps2_kbd_matrix #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 9830
) (
    input  logic        mck,
    input  logic        rin_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [8:0]  map_addr,
    input  logic [6:0]  map_data,
    output logic [63:0] kbmat,
    output logic        kb_any,
    output logic        kb_event,
    output logic        kb_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    // ---------------- input synchronisers and edge detect ----------------
    // Reset to 0 so that an idle-high line after reset looks like a rising
    // edge, never a spurious falling one.
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_q;
    logic                   clk_s, dat_s, fall;

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            clk_sync <= '0;
            dat_sync <= '0;
            clk_q    <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            clk_q    <= clk_s;
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];
    assign fall  = clk_q & ~clk_s;

    // ---------------- receive FSM ----------------
    typedef enum logic {RX_IDLE, RX_BITS} rx_t;
    rx_t           rx_state, rx_next;
    logic [3:0]    bitcnt;
    logic [10:0]   shreg;
    logic [10:0]   frame;
    logic [TW-1:0] tcnt;
    logic          frame_done, frame_ok, tmo;
    logic          byte_rdy;
    logic [7:0]    rx_byte;

    // Frame view including the bit arriving this cycle: LSB-first shift, so
    // after 11 shifts frame[0]=start, [8:1]=data, [9]=parity, [10]=stop.
    assign frame    = {dat_s, shreg[10:1]};
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    always_comb begin
        rx_next    = rx_state;
        frame_done = 1'b0;
        tmo        = 1'b0;
        case (rx_state)
            RX_IDLE: if (fall) rx_next = RX_BITS;
            RX_BITS: begin
                if (fall) begin
                    if (bitcnt == 4'd10) begin
                        frame_done = 1'b1;
                        rx_next    = RX_IDLE;
                    end
                end else if (tcnt == TW'(TIMEOUT)) begin
                    // edge has priority over the timeout
                    tmo     = 1'b1;
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            rx_state <= RX_IDLE;
            bitcnt   <= '0;
            shreg    <= '0;
            tcnt     <= '0;
            byte_rdy <= 1'b0;
            rx_byte  <= '0;
            kb_err   <= 1'b0;
        end else begin
            rx_state <= rx_next;
            if (fall) shreg <= frame;
            if (rx_next == RX_IDLE) bitcnt <= '0;
            else if (fall)          bitcnt <= bitcnt + 4'd1;
            if (fall || rx_state == RX_IDLE) tcnt <= '0;
            else if (tcnt != TW'(TIMEOUT))   tcnt <= tcnt + 1'b1;
            byte_rdy <= frame_done & frame_ok;
            if (frame_done) rx_byte <= frame[8:1];
            kb_err   <= (frame_done & ~frame_ok) | tmo;
        end
    end

    // ---------------- decode FSM ----------------
    typedef enum logic [1:0] {D_IDLE, D_LOOK, D_APPLY, D_SKIP} d_t;
    d_t         d_state, d_next;
    logic       ext, brk, pfx;
    logic [2:0] skip;
    logic       set_ext, set_brk, clr_pfx, clr_mat, load_addr, load_skip, apply;

    assign pfx = ext | brk;

    always_comb begin
        d_next    = d_state;
        set_ext   = 1'b0;
        set_brk   = 1'b0;
        clr_pfx   = 1'b0;
        clr_mat   = 1'b0;
        load_addr = 1'b0;
        load_skip = 1'b0;
        apply     = 1'b0;
        case (d_state)
            D_IDLE: if (byte_rdy) begin
                case (rx_byte)
                    8'hE0: set_ext = 1'b1;
                    8'hF0: set_brk = 1'b1;
                    8'hE1: begin
                        load_skip = 1'b1;
                        d_next    = D_SKIP;
                    end
                    8'h00, 8'hFF: begin
                        clr_mat = 1'b1;
                        clr_pfx = 1'b1;
                    end
                    default: begin
                        if (rx_byte == 8'hAA && !pfx) begin
                            clr_mat = 1'b1;
                        end else if ((rx_byte == 8'hFA || rx_byte == 8'hFE ||
                                      rx_byte == 8'hEE) && !pfx) begin
                            // keyboard protocol responses, not keys
                        end else if (ext && (rx_byte == 8'h12 || rx_byte == 8'h59)) begin
                            clr_pfx = 1'b1;
                        end else begin
                            load_addr = 1'b1;
                            d_next    = D_LOOK;
                        end
                    end
                endcase
            end
            D_LOOK:  d_next = D_APPLY;
            D_APPLY: begin
                apply   = map_data[6];
                clr_pfx = 1'b1;
                d_next  = D_IDLE;
            end
            D_SKIP: if (byte_rdy && skip <= 3'd1) begin
                clr_pfx = 1'b1;
                d_next  = D_IDLE;
            end
            default: d_next = D_IDLE;
        endcase
    end

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            d_state  <= D_IDLE;
            ext      <= 1'b0;
            brk      <= 1'b0;
            skip     <= '0;
            map_addr <= '0;
            kbmat    <= '0;
            kb_event <= 1'b0;
            kb_any   <= 1'b0;
        end else begin
            d_state <= d_next;
            if (clr_pfx)      ext <= 1'b0;
            else if (set_ext) ext <= 1'b1;
            if (clr_pfx)      brk <= 1'b0;
            else if (set_brk) brk <= 1'b1;
            if (load_skip)                         skip <= 3'd7;
            else if (d_state == D_SKIP && byte_rdy) skip <= skip - 3'd1;
            if (load_addr) map_addr <= {ext, rx_byte};
            if (clr_mat)    kbmat <= '0;
            else if (apply) kbmat[map_data[5:0]] <= ~brk;
            kb_event <= apply;
            kb_any   <= |kbmat;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_matrix.sv
module tb_ps2_kbd_matrix;

    localparam int TMO = 200;

    logic        mck = 1'b0;
    logic        rin_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [8:0]  map_addr;
    logic [6:0]  map_data;
    logic [63:0] kbmat;
    logic        kb_any, kb_event, kb_err;

    always #5 mck = ~mck;

    ps2_kbd_matrix #(.SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
        .mck(mck), .rin_n(rin_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .map_addr(map_addr), .map_data(map_data), .kbmat(kbmat),
        .kb_any(kb_any), .kb_event(kb_event), .kb_err(kb_err)
    );

    // lookup ROM model, registered read
    function automatic logic [6:0] rom(input logic [8:0] a);
        case (a)
            9'h01C:  return {1'b1, 6'd13};
            9'h175:  return {1'b1, 6'd42};
            9'h075:  return {1'b1, 6'd7};
            9'h01B:  return {1'b1, 6'd3};
            9'h023:  return {1'b1, 6'd60};
            default: return 7'h00;
        endcase
    endfunction

    always @(posedge mck) map_data <= rom(map_addr);

    typedef struct {
        logic [63:0] mat;
        logic [8:0]  addr;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        bit         flip;
        bit         ev;
        logic [8:0] addr;
        int         idx;
        bit         val;
        bit         clr;
    } vec_t;

    exp_t        q[$];
    vec_t        vt[$];
    logic [63:0] exp_mat = '0;
    int          exp_err = 0;
    int          err_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // one mck cycle, sampled on the falling edge; scoreboard watches events
    task automatic tick();
        exp_t e;
        @(negedge mck);
        if (!rin_n) return;
        if (kb_err) err_cnt++;
        if (kb_event) begin
            if (q.size() == 0) begin
                chk("unexpected_kb_event", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("event_kbmat", kbmat, e.mat);
                chk("event_map_addr", 64'(map_addr), 64'(e.addr));
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bits(input logic [7:0] b, input bit flip, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            ticks(10);
            ps2_clk = 1'b0;
            ticks(20);
            ps2_clk = 1'b1;
            ticks(10);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic expect_write(input logic [8:0] addr, input int idx, input bit val);
        exp_t e;
        exp_mat[idx] = val;
        e.mat  = exp_mat;
        e.addr = addr;
        q.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        if (v.ev)   expect_write(v.addr, v.idx, v.val);
        if (v.clr)  exp_mat = '0;
        if (v.flip) exp_err++;
        send_bits(v.b, v.flip, 11);
        ticks(15);
    endtask

    task automatic settle_check(input string nm);
        chk({nm, "_kbmat"}, kbmat, exp_mat);
        chk({nm, "_kb_any"}, 64'(kb_any), 64'(|exp_mat));
        chk({nm, "_kb_err_count"}, 64'(err_cnt), 64'(exp_err));
        chk({nm, "_pending"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        // b, flip, ev, addr, idx, val, clr
        vt.push_back('{8'h1C, 0, 1, 9'h01C, 13, 1, 0});
        vt.push_back('{8'hF0, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'h1C, 0, 1, 9'h01C, 13, 0, 0});
        vt.push_back('{8'h1C, 1, 0, 9'h000,  0, 0, 0});   // parity error
        vt.push_back('{8'h1C, 0, 1, 9'h01C, 13, 1, 0});
        vt.push_back('{8'h1C, 0, 1, 9'h01C, 13, 1, 0});   // typematic repeat
        vt.push_back('{8'hF0, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'h1C, 0, 1, 9'h01C, 13, 0, 0});
        vt.push_back('{8'hE0, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'h75, 0, 1, 9'h175, 42, 1, 0});
        vt.push_back('{8'hE0, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'hF0, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'h75, 0, 1, 9'h175, 42, 0, 0});
        vt.push_back('{8'hE0, 0, 0, 9'h000,  0, 0, 0});   // fake shift
        vt.push_back('{8'h12, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'hF0, 0, 0, 9'h000,  0, 0, 0});   // break of unheld key
        vt.push_back('{8'h1C, 0, 1, 9'h01C, 13, 0, 0});
        vt.push_back('{8'h0E, 0, 0, 9'h000,  0, 0, 0});   // unmapped code
        vt.push_back('{8'h1B, 0, 1, 9'h01B,  3, 1, 0});
        vt.push_back('{8'h23, 0, 1, 9'h023, 60, 1, 0});
        vt.push_back('{8'hFA, 0, 0, 9'h000,  0, 0, 0});   // ack ignored
        vt.push_back('{8'hAA, 0, 0, 9'h000,  0, 0, 1});   // BAT clears
        vt.push_back('{8'hE1, 0, 0, 9'h000,  0, 0, 0});   // pause sequence
        vt.push_back('{8'h14, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'h77, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'hE1, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'hF0, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'h14, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'hF0, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'h77, 0, 0, 9'h000,  0, 0, 0});
        vt.push_back('{8'h1B, 0, 1, 9'h01B,  3, 1, 0});
        vt.push_back('{8'h23, 0, 1, 9'h023, 60, 1, 0});
        vt.push_back('{8'hFF, 0, 0, 9'h000,  0, 0, 1});   // overrun clears

        ticks(3);
        chk("reset_kbmat", kbmat, 64'd0);
        chk("reset_outs", 64'({map_addr, kb_any, kb_event, kb_err}), 64'd0);
        rin_n = 1'b1;
        ticks(5);

        for (int i = 0; i < vt.size(); i++) begin
            run_vec(vt[i]);
            settle_check($sformatf("vec%0d", i));
        end

        // timeout: 5 bits then idle high beyond TIMEOUT
        send_bits(8'h75, 0, 5);
        exp_err++;
        ticks(TMO + 10);
        chk("timeout_err_count", 64'(err_cnt), 64'(exp_err));
        chk("timeout_kbmat", kbmat, exp_mat);
        run_vec('{8'h75, 0, 1, 9'h075, 7, 1, 0});
        settle_check("after_timeout");

        // async reset mid-frame with keys held
        run_vec('{8'h1B, 0, 1, 9'h01B, 3, 1, 0});
        run_vec('{8'h23, 0, 1, 9'h023, 60, 1, 0});
        settle_check("before_reset");
        send_bits(8'h1C, 0, 4);
        #3 rin_n = 1'b0;
        #1;
        chk("async_reset_kbmat", kbmat, 64'd0);
        chk("async_reset_outs", 64'({map_addr, kb_any, kb_event, kb_err}), 64'd0);
        exp_mat = '0;
        q.delete();
        ticks(3);
        rin_n = 1'b1;
        ticks(5);
        run_vec('{8'h1C, 0, 1, 9'h01C, 13, 1, 0});
        settle_check("after_reset");

        ticks(20);
        chk("final_pending", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_matrix.md
Name: ps2_kbd_matrix

Overview:
- Upstream of the Blink keyboard port: deserialises a PS/2 (scan-code set 2) keyboard stream and maintains the 64-bit key matrix Blink reads through IO $B2.
- Scan codes are translated to matrix positions through an external lookup ROM, addressed by this block with a fixed 1-cycle read latency.
- Runs on the 9.83MHz master clock.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on ps2_clk and ps2_dat (minimum 2).
- TIMEOUT, 9830, idle mck cycles allowed between PS/2 falling edges inside a frame (about 1ms).

Ports:
- mck  in  1  master clock, all logic on the rising edge.
- rin_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  PS/2 clock from the keyboard; asynchronous to mck.
- ps2_dat  in  1  PS/2 data from the keyboard; asynchronous to mck.
- map_addr  out  9  ROM address {ext, scancode}.
- map_data  in  7  ROM data {valid, index[5:0]}, valid 1 cycle after map_addr changes.
- kbmat  out  64  key matrix; bit 8*row+col is 1 while the key is held.
- kb_any  out  1  OR of all kbmat bits (wake hint).
- kb_event  out  1  1-cycle pulse when a kbmat bit is written.
- kb_err  out  1  1-cycle pulse on a framing, parity or timeout error.

Behaviour:
Reset:
- rin_n low clears everything asynchronously: kbmat=0, kb_any=0, kb_event=0, kb_err=0, map_addr=0, all FSMs idle, prefixes cleared.
- Reset mid-frame discards the partial frame.

Input sampling:
- ps2_clk and ps2_dat each pass through SYNC_STAGES flops.
- Edge = previous synchronised clock 1, current 0.
- Data is sampled from the synchronised line on the edge cycle.

Receive FSM, states RX_IDLE and RX_BITS:
- RX_IDLE: an edge shifts in the start bit, sets bitcnt=1 and moves to RX_BITS.
- RX_BITS: each edge shifts one bit, LSB-first; frame order is start, d0..d7, parity, stop (11 bits).
- On the 11th bit: frame is good when start==0, stop==1 and XOR(d0..d7,parity)==1.
  - Good frame: byte_rdy pulses for 1 cycle.
  - Bad frame: kb_err pulses for 1 cycle and the byte is discarded.
  - Either way, return to RX_IDLE.
- Timeout counter clears on every edge and counts in RX_BITS. When it reaches TIMEOUT: kb_err pulses, bitcnt=0, state returns to RX_IDLE.
- An edge and the timeout in the same cycle: the edge wins.

Decode FSM, states D_IDLE, D_LOOK, D_APPLY, D_SKIP. Actions on byte_rdy in D_IDLE:
- E0: set ext.
- F0: set brk.
- E1: skip=7, go to D_SKIP (swallows the Pause sequence).
- 00 or FF (keyboard overrun): kbmat=0, clear ext and brk.
- AA with no prefix pending (BAT pass): kbmat=0.
- FA, FE or EE with no prefix pending: ignored.
- ext=1 with byte 12 or 59 (fake shift): ignored, clear ext and brk.
- Any other byte: map_addr<={ext,byte}, go to D_LOOK.

Decode FSM transitions:
- D_LOOK: wait 1 cycle, go to D_APPLY.
- D_APPLY:
  - If map_data[6]=1: kbmat[map_data[5:0]]<=~brk and kb_event pulses.
  - If map_data[6]=0: kbmat is unchanged and no kb_event.
  - Clear ext and brk; go to D_IDLE.
- D_SKIP: each byte_rdy decrements skip; at skip==0, clear ext and brk and go to D_IDLE.

Timing and output rules:
- Lookup completes 2 cycles after byte_rdy. The next byte_rdy cannot arrive sooner than about 0.5ms, so no overlap handling is needed.
- Total latency from the stop-bit edge (synchronised) to the kbmat update is 3 mck cycles.
- Repeated make codes (typematic) rewrite 1; this is idempotent and still pulses kb_event.
- A break code for a key not held writes 0 and pulses kb_event.
- kb_any is registered and follows kbmat with 1 cycle of latency.
- A kb_err frame never affects the prefix state.

Test Plan:
- ROM maps 01C to valid index 13. Send 1C, then F0 1C → kbmat[13] goes 0→1→0; kb_event pulses twice; map_addr=0x01C.
- Send 1C with its parity bit flipped → kb_err pulses once; kbmat unchanged; following good frame 1C sets bit 13.
- Send 5 bits, then hold ps2_clk high for TIMEOUT+10 cycles → exactly one kb_err; next frame 75 decodes normally.
- ROM maps 175 to index 42 and 075 to index 7. Send E0 75, then E0 F0 75 → map_addr=0x175; bit 42 set then cleared; bit 7 never touched.
- Hold keys at indices 3 and 60 (kb_any=1), then send AA → kbmat=0 and kb_any=0 one cycle later. Separately send E1 14 77 E1 F0 14 F0 77 → no kbmat change, no kb_event.
- Pulse rin_n low asynchronously mid-frame with keys held → all outputs 0 immediately; next full frame decodes correctly.
